pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side sequencer for the MIPS core. It owns the architectural PC register and chooses each next fetch address from sequential increment or one of four redirect sources (jal, jump, jr, branch). It drives the req/ready handshake to instruction memory, handles decode stalls, and discards a fetch that is overtaken by a redirect while in flight. It sits between the control unit and branch/jump address generation on one side, and instruction memory and decode on the other.

## Interface
- RESET_PC, 32'h0000_0000, first word address fetched after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept an instruction; hold fetch
- jal_req  in  1  jump-and-link redirect request
- jal_target  in  32  jal target word address
- jump_req  in  1  jump redirect request
- jump_target  in  32  jump target word address
- jr_req  in  1  jump-register redirect request
- jr_target  in  27  jr target; zero-extended to 32
- branch_req  in  1  branch redirect request
- branch_target  in  32  branch target; 32'hFFFF_FFFF means not taken
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch word address
- imem_ready  in  1  instruction memory completes the current request this cycle
- pc  out  32  address of the instruction delivered to decode
- pc_valid  out  1  one-cycle pulse; pc holds a newly fetched instruction address
- flush  out  1  one-cycle pulse; a redirect was accepted and younger work must be killed

## Operation
- Registers: state, fetch_addr, pc, pc_valid, flush, pend_addr, drop.
- Redirect valid: `redir = branch_ok | jr_req | jump_req | jal_req`, where `branch_ok = branch_req & (branch_target != 32'hFFFF_FFFF)`.
- Priority, highest first: branch_ok, jr, jump, jal. The winning target is `redir_tgt`.
- States:
  - BOOT: entered during reset. Goes to FETCH on the first clock after rst_n rises.
  - FETCH: imem_req=1, imem_addr=fetch_addr. req and addr stay stable until imem_ready.
  - HOLD: imem_req=0. Entered on completion when stall=1. Returns to FETCH on the first cycle stall=0.
- FETCH with imem_ready=0 and redir=1:
  - pend_addr <= redir_tgt; drop <= 1; flush pulses.
  - A later redirect before completion overwrites pend_addr (newest wins).
- FETCH with imem_ready=1 (completion):
  - redir=1 this cycle: fetch_addr <= redir_tgt, flush pulses, no pc_valid. Overrides any pending target.
  - Else if drop=1: fetch_addr <= pend_addr, drop <= 0, no pc_valid.
  - Else: pc <= fetch_addr, pc_valid <= 1, fetch_addr <= fetch_addr + 1.
  - Next state: HOLD if stall=1, else FETCH.
- HOLD with redir=1: fetch_addr <= redir_tgt, flush pulses, stay in HOLD while stall=1.
- BOOT ignores redirects.
- Arithmetic: 32-bit word addresses; increment wraps 32'hFFFF_FFFF to 0. jr_target becomes {5'b0, jr_target}.

## Timing
- Reset values (asynchronous): state=BOOT, fetch_addr=RESET_PC, pc=0, pc_valid=0, flush=0, drop=0, pend_addr=0, imem_req=0.
- imem_addr = fetch_addr at all times.
- imem_req is a combinational decode of state.
- First imem_req appears in the first cycle after the first rising clk with rst_n=1.
- Latency: with imem_ready tied high and no stall, the core receives one pc_valid per cycle. pc_valid rises the cycle after completion.
- Redirect to first fetch of the target:
  - In HOLD or at completion: the target is presented on the next FETCH cycle.
  - In flight: the target is presented in the cycle after the dropped completion.
- Simultaneous stall and redirect at completion: the redirect is applied, then the block enters HOLD.
- flush and pc_valid are never high in the same cycle.
- rst_n low mid-fetch: imem_req drops immediately and the in-flight response is abandoned.

## Test plan
- Reset release, RESET_PC=0x100, imem_ready=1, no redirects -> imem_addr 0x100, 0x101, 0x102 on consecutive cycles; pc_valid high each cycle after the first with pc=0x100, 0x101, ...
- All four requests high in the same completion cycle, branch_target=0x40, jr_target=0x50, jump_target=0x60, jal_target=0x70 -> next fetch at 0x40. Repeat with branch_target=0xFFFF_FFFF -> next fetch at 0x50.
- Fetch at 0x10 with imem_ready held low 3 cycles; jump_req to 0x80 in cycle 1, then jal_req to 0x90 in cycle 2 -> flush pulses twice, completion yields no pc_valid, next fetch at 0x90.
- stall=1 at completion of 0x20 for 4 cycles -> imem_req=0 for 4 cycles; then fetch at 0x21; pc stays 0x20 throughout.
- fetch_addr=0xFFFF_FFFF completes -> next imem_addr=0x0000_0000.
- rst_n pulsed low mid-wait at 0x33 -> imem_req=0 and pc_valid=0 asynchronously; after release, first fetch at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch-side sequencer for the MIPS core. Owns the architectural PC and picks
// each next fetch word address. The next address comes from the sequential
// increment or from one of four redirect sources. It drives the req/ready
// handshake to instruction memory and holds fetch while decode stalls. A fetch
// that a redirect overtakes while it is in flight is thrown away.
//
// Ports
//   i_clk, i_rst_n        clock and asynchronous active-low reset
//   i_stall               decode cannot accept an instruction; hold fetch
//   i_jal_req/_target     jump-and-link redirect (32-bit word address)
//   i_jump_req/_target    jump redirect (32-bit word address)
//   i_jr_req/_target      jump-register redirect (27 bits, zero-extended)
//   i_branch_req/_target  branch redirect; target 32'hFFFF_FFFF = not taken
//   o_imem_req            fetch request to instruction memory
//   o_imem_addr           fetch word address (always the current fetch address)
//   i_imem_ready          instruction memory completes the request this cycle
//   o_pc                  address of the instruction delivered to decode
//   o_pc_valid            one-cycle pulse: o_pc holds a newly fetched address
//   o_flush               one-cycle pulse: redirect accepted, kill younger work
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_jal_req,
  input  logic [31:0] i_jal_target,
  input  logic        i_jump_req,
  input  logic [31:0] i_jump_target,
  input  logic        i_jr_req,
  input  logic [26:0] i_jr_target,
  input  logic        i_branch_req,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  output logic [31:0] o_pc,
  output logic        o_pc_valid,
  output logic        o_flush
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_addr;
  logic [31:0] r_pc;
  logic        r_pc_valid;
  logic        r_flush;
  logic [31:0] r_pend_addr;
  logic        r_drop;

  state_t      w_state_nxt;
  logic [31:0] w_fetch_addr_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_pc_valid_nxt;
  logic        w_flush_nxt;
  logic [31:0] w_pend_addr_nxt;
  logic        w_drop_nxt;

  logic        w_branch_ok;
  logic        w_redir;
  logic [31:0] w_redir_tgt;

  // An all-ones branch target is the not-taken marker, so it never redirects.
  assign w_branch_ok = i_branch_req && (i_branch_target != 32'hFFFF_FFFF);
  assign w_redir     = w_branch_ok || i_jr_req || i_jump_req || i_jal_req;

  // Redirect priority: branch, then jr, then jump, then jal.
  always_comb begin
    w_redir_tgt = i_jal_target;
    if (w_branch_ok) begin
      w_redir_tgt = i_branch_target;
    end else if (i_jr_req) begin
      w_redir_tgt = {5'b0, i_jr_target};
    end else if (i_jump_req) begin
      w_redir_tgt = i_jump_target;
    end
  end

  // Next-state and next-register logic. pc_valid and flush default low so
  // they only ever pulse for one cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_addr_nxt = r_fetch_addr;
    w_pc_nxt         = r_pc;
    w_pc_valid_nxt   = 1'b0;
    w_flush_nxt      = 1'b0;
    w_pend_addr_nxt  = r_pend_addr;
    w_drop_nxt       = r_drop;

    unique case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
      end

      FETCH: begin
        if (i_imem_ready) begin
          if (w_redir) begin
            // A redirect at completion beats any target parked while in flight.
            w_fetch_addr_nxt = w_redir_tgt;
            w_flush_nxt      = 1'b1;
            w_drop_nxt       = 1'b0;
          end else if (r_drop) begin
            // This response belongs to a path that was already redirected.
            w_fetch_addr_nxt = r_pend_addr;
            w_drop_nxt       = 1'b0;
          end else begin
            w_pc_nxt         = r_fetch_addr;
            w_pc_valid_nxt   = 1'b1;
            w_fetch_addr_nxt = r_fetch_addr + 32'd1;
          end
          w_state_nxt = i_stall ? HOLD : FETCH;
        end else if (w_redir) begin
          // The request address must stay stable until it completes. The
          // target is parked here, and the newest redirect wins.
          w_pend_addr_nxt = w_redir_tgt;
          w_drop_nxt      = 1'b1;
          w_flush_nxt     = 1'b1;
        end
      end

      HOLD: begin
        if (w_redir) begin
          w_fetch_addr_nxt = w_redir_tgt;
          w_flush_nxt      = 1'b1;
        end
        if (!i_stall) begin
          w_state_nxt = FETCH;
        end
      end

      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= BOOT;
      r_fetch_addr <= RESET_PC;
      r_pc         <= 32'h0;
      r_pc_valid   <= 1'b0;
      r_flush      <= 1'b0;
      r_pend_addr  <= 32'h0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_pc         <= w_pc_nxt;
      r_pc_valid   <= w_pc_valid_nxt;
      r_flush      <= w_flush_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  assign o_imem_req  = (r_state == FETCH);
  assign o_imem_addr = r_fetch_addr;
  assign o_pc        = r_pc;
  assign o_pc_valid  = r_pc_valid;
  assign o_flush     = r_flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Testbench for pc_sequencer. It runs directed scenarios and then random
// traffic. A behavioural model checks every cycle: it tracks whether a fetch
// is outstanding, whether the current response is already stale, and where
// fetch goes next.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rstN;
  logic        stall;
  logic        jalReq, jumpReq, jrReq, branchReq;
  logic [31:0] jalTgt, jumpTgt, branchTgt;
  logic [26:0] jrTgt;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] pc;
  logic        pcValid;
  logic        flush;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  bit          mStarted;
  bit          mRequesting;
  bit          mStale;
  logic [31:0] mFetch;
  logic [31:0] mParked;
  logic [31:0] mPc;
  bit          mPcValid;
  bit          mFlush;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_stall(stall),
    .i_jal_req(jalReq),
    .i_jal_target(jalTgt),
    .i_jump_req(jumpReq),
    .i_jump_target(jumpTgt),
    .i_jr_req(jrReq),
    .i_jr_target(jrTgt),
    .i_branch_req(branchReq),
    .i_branch_target(branchTgt),
    .o_imem_req(imemReq),
    .o_imem_addr(imemAddr),
    .i_imem_ready(imemReady),
    .o_pc(pc),
    .o_pc_valid(pcValid),
    .o_flush(flush)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic resetModel();
    mStarted    = 0;
    mRequesting = 0;
    mStale      = 0;
    mFetch      = RST_PC;
    mParked     = 32'h0;
    mPc         = 32'h0;
    mPcValid    = 0;
    mFlush      = 0;
  endtask

  // Scan the redirect sources in priority order and take the first live one.
  task automatic pickRedirect(output bit hit, output logic [31:0] tgt);
    bit          live [4];
    logic [31:0] dest [4];
    live[0] = branchReq && (branchTgt != 32'hFFFF_FFFF); dest[0] = branchTgt;
    live[1] = jrReq;   dest[1] = {5'b0, jrTgt};
    live[2] = jumpReq; dest[2] = jumpTgt;
    live[3] = jalReq;  dest[3] = jalTgt;
    hit = 0;
    tgt = 32'h0;
    for (int k = 3; k >= 0; k--) begin
      if (live[k]) begin
        hit = 1;
        tgt = dest[k];
      end
    end
  endtask

  // Advance the model by one rising edge, using the inputs now being driven.
  task automatic stepModel();
    bit          hit;
    logic [31:0] tgt;
    pickRedirect(hit, tgt);
    mPcValid = 0;
    mFlush   = 0;
    if (!mStarted) begin
      mStarted    = 1;
      mRequesting = 1;
    end else if (mRequesting && imemReady) begin
      if (hit) begin
        mFetch = tgt; mFlush = 1; mStale = 0;
      end else if (mStale) begin
        mFetch = mParked; mStale = 0;
      end else begin
        mPc = mFetch; mPcValid = 1; mFetch = mFetch + 32'd1;
      end
      mRequesting = !stall;
    end else if (mRequesting) begin
      if (hit) begin
        mParked = tgt; mStale = 1; mFlush = 1;
      end
    end else begin
      if (hit) begin
        mFetch = tgt; mFlush = 1;
      end
      if (!stall) mRequesting = 1;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".imem_req"},  {31'b0, imemReq},  {31'b0, mRequesting});
    checkValue({tag, ".imem_addr"}, imemAddr,          mFetch);
    checkValue({tag, ".pc"},        pc,                mPc);
    checkValue({tag, ".pc_valid"},  {31'b0, pcValid},  {31'b0, mPcValid});
    checkValue({tag, ".flush"},     {31'b0, flush},    {31'b0, mFlush});
    checkValue({tag, ".exclusive"}, {31'b0, pcValid && flush}, 32'h0);
  endtask

  // Drive one cycle of inputs. reqs = {branch, jr, jump, jal}. Then clock
  // the design and the model and compare just after the edge.
  task automatic applyStimulus(input logic st, input logic rdy, input logic [3:0] reqs);
    stall     = st;
    imemReady = rdy;
    branchReq = reqs[3];
    jrReq     = reqs[2];
    jumpReq   = reqs[1];
    jalReq    = reqs[0];
    stepModel();
    @(posedge clk);
    #1;
    checkOutput("cycle");
  endtask

  task automatic setTargets(input logic [31:0] br, input logic [26:0] jr,
                            input logic [31:0] jmp, input logic [31:0] jal);
    branchTgt = br;
    jrTgt     = jr;
    jumpTgt   = jmp;
    jalTgt    = jal;
  endtask

  initial begin
    rstN = 1'b0;
    stall = 0; imemReady = 1;
    jalReq = 0; jumpReq = 0; jrReq = 0; branchReq = 0;
    setTargets(32'h0, 27'h0, 32'h0, 32'h0);
    resetModel();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset.imem_req", {31'b0, imemReq}, 32'h0);
    checkValue("reset.imem_addr", imemAddr, RST_PC);
    checkValue("reset.pc", pc, 32'h0);
    checkValue("reset.pc_valid", {31'b0, pcValid}, 32'h0);
    checkValue("reset.flush", {31'b0, flush}, 32'h0);
    rstN = 1'b1;

    // Sequential fetch from RESET_PC
    applyStimulus(0, 1, 4'b0000);
    checkValue("boot.first_addr", imemAddr, 32'h100);
    checkValue("boot.first_req", {31'b0, imemReq}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b0000);
      checkValue("seq.addr", imemAddr, 32'h101 + i);
      checkValue("seq.pc", pc, 32'h100 + i);
      checkValue("seq.valid", {31'b0, pcValid}, 32'h1);
    end

    // Priority: branch wins, then jr when branch is not taken
    setTargets(32'h40, 27'h50, 32'h60, 32'h70);
    applyStimulus(0, 1, 4'b1111);
    checkValue("prio.branch", imemAddr, 32'h40);
    checkValue("prio.flush", {31'b0, flush}, 32'h1);
    checkValue("prio.novalid", {31'b0, pcValid}, 32'h0);
    branchTgt = 32'hFFFF_FFFF;
    applyStimulus(0, 1, 4'b1111);
    checkValue("prio.jr", imemAddr, 32'h50);
    applyStimulus(0, 1, 4'b0000);
    checkValue("prio.after_pc", pc, 32'h50);

    // In-flight redirects: two flushes, dropped completion, newest target
    jumpTgt = 32'h10;
    applyStimulus(0, 1, 4'b0010);
    checkValue("drop.start", imemAddr, 32'h10);
    jumpTgt = 32'h80;
    applyStimulus(0, 0, 4'b0010);
    checkValue("drop.flush1", {31'b0, flush}, 32'h1);
    checkValue("drop.addr_stable", imemAddr, 32'h10);
    jalTgt = 32'h90;
    applyStimulus(0, 0, 4'b0001);
    checkValue("drop.flush2", {31'b0, flush}, 32'h1);
    applyStimulus(0, 0, 4'b0000);
    checkValue("drop.flush_clear", {31'b0, flush}, 32'h0);
    applyStimulus(0, 1, 4'b0000);
    checkValue("drop.novalid", {31'b0, pcValid}, 32'h0);
    checkValue("drop.newest", imemAddr, 32'h90);
    applyStimulus(0, 1, 4'b0000);
    checkValue("drop.target_pc", pc, 32'h90);

    // Stall at completion of 0x20 for 4 cycles
    jumpTgt = 32'h20;
    applyStimulus(0, 1, 4'b0010);
    applyStimulus(1, 1, 4'b0000);
    checkValue("stall.pc", pc, 32'h20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 4'b0000);
      checkValue("stall.noreq", {31'b0, imemReq}, 32'h0);
      checkValue("stall.pc_hold", pc, 32'h20);
    end
    applyStimulus(0, 1, 4'b0000);
    checkValue("stall.resume", imemAddr, 32'h21);
    checkValue("stall.resume_req", {31'b0, imemReq}, 32'h1);

    // Stall and redirect together at completion
    jumpTgt = 32'h30;
    applyStimulus(1, 1, 4'b0010);
    checkValue("stallredir.noreq", {31'b0, imemReq}, 32'h0);
    applyStimulus(0, 1, 4'b0000);
    checkValue("stallredir.addr", imemAddr, 32'h30);

    // Wrap and jr zero-extension
    jumpTgt = 32'hFFFF_FFFF;
    applyStimulus(0, 1, 4'b0010);
    applyStimulus(0, 1, 4'b0000);
    checkValue("wrap.addr", imemAddr, 32'h0);
    checkValue("wrap.pc", pc, 32'hFFFF_FFFF);
    jrTgt = 27'h7FF_FFFF;
    applyStimulus(0, 1, 4'b0100);
    checkValue("jr.zext", imemAddr, 32'h07FF_FFFF);

    // Asynchronous reset while waiting on 0x33
    jumpTgt = 32'h32;
    applyStimulus(0, 1, 4'b0010);
    applyStimulus(0, 1, 4'b0000);
    checkValue("areset.pre_addr", imemAddr, 32'h33);
    imemReady = 0;
    #2 rstN = 1'b0;
    #1;
    checkValue("areset.req", {31'b0, imemReq}, 32'h0);
    checkValue("areset.valid", {31'b0, pcValid}, 32'h0);
    checkValue("areset.addr", imemAddr, RST_PC);
    resetModel();
    @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(0, 1, 4'b0000);
    checkValue("areset.refetch", imemAddr, RST_PC);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      setTargets(($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom(),
                 27'($urandom()), $urandom(), $urandom());
      applyStimulus($urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) != 0,
                    {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
